// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter through a DATA/STROBE handshake gated by TX_BUSY.
// Latency: push visible in LEVEL after 1 edge; first strobe 1 edge after the byte lands; pop on the edge that drops the strobe.
// Backpressure: none beyond FULL; a push into a full queue with no pop is dropped and sets sticky OVERFLOW.
module uart_tx_queue #(
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [7:0]            WR_DATA,
  input  logic                  WR_EN,
  input  logic                  FLUSH,
  input  logic                  CLEAR_OVF,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  OVERFLOW,
  output logic [7:0]            TX_DATA,
  output logic                  TX_STROBE,
  input  logic                  TX_BUSY
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  strobe_q, strobe_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  state_t                state_q, state_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Queue bookkeeping: the pop is the cycle the strobe is visible, so a full queue can still accept a push then.
  always_comb begin
    full     = (level_q == (DEPTH_LOG2 + 1)'(DEPTH));
    empty    = (level_q == '0);
    pop      = strobe_q && !FLUSH;
    push     = WR_EN && (!full || strobe_q) && !FLUSH;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      if (push && !pop)      level_d = level_q + (DEPTH_LOG2 + 1)'(1);
      else if (pop && !push) level_d = level_q - (DEPTH_LOG2 + 1)'(1);
    end
    // A dropped push beats a simultaneous clear.
    if (WR_EN && !FLUSH && full && !strobe_q) ovf_d = 1'b1;
    else if (CLEAR_OVF)                       ovf_d = 1'b0;
  end

  // Sequencer next-state: strobe once per byte, then wait for busy (or the timeout) and for busy to fall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    strobe_d  = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (!empty && !TX_BUSY && !FLUSH) begin
          tx_data_d = mem_q[rd_ptr_q];
          strobe_d  = 1'b1;
          cnt_d     = '0;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (TX_BUSY) begin
          state_d = S_DONE;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (!TX_BUSY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte storage has no reset; contents are only read behind a valid level.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= WR_DATA;
  end

  // Control and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      tx_data_q <= 8'h00;
      strobe_q  <= 1'b0;
      cnt_q     <= '0;
      state_q   <= S_IDLE;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      tx_data_q <= tx_data_d;
      strobe_q  <= strobe_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
    end
  end

  assign FULL      = full;
  assign EMPTY     = empty;
  assign LEVEL     = level_q;
  assign OVERFLOW  = ovf_q;
  assign TX_DATA   = tx_data_q;
  assign TX_STROBE = strobe_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Testbench for uart_tx_queue: directed scenarios plus a random phase against a queue-based reference.
// The reference holds the stored bytes in a queue; each strobe is checked against its head.
// A simple transmitter model raises TX_BUSY for 10 cycles per strobe, or holds it high/low.
module tb_uart_tx_queue;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;
  localparam int ACKT  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [7:0]     wr_data = 8'h00;
  logic           wr_en = 1'b0;
  logic           flush = 1'b0;
  logic           clear_ovf = 1'b0;
  logic           tx_busy = 1'b0;
  logic           full, empty, overflow, tx_strobe;
  logic [DL2:0]   level;
  logic [7:0]     tx_data;

  uart_tx_queue #(.DEPTH_LOG2(DL2), .ACK_TIMEOUT(ACKT)) dut (
    .CLK(clk), .RESET(rst), .WR_DATA(wr_data), .WR_EN(wr_en), .FLUSH(flush),
    .CLEAR_OVF(clear_ovf), .FULL(full), .EMPTY(empty), .LEVEL(level),
    .OVERFLOW(overflow), .TX_DATA(tx_data), .TX_STROBE(tx_strobe), .TX_BUSY(tx_busy)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sent[$];
  int         strobe_cyc[$];
  bit         exp_ovf     = 1'b0;
  bit         pop_pending = 1'b0;
  bit         prev_strobe = 1'b0;
  int         busy_mode   = 0;   // 0: transmitter model, 1: stuck high, 2: stuck low
  int         busy_cnt    = 0;
  int         cycle_no    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_busy_mode(input int m);
    busy_mode = m;
    busy_cnt  = 0;
    tx_busy   = (m == 1);
  endtask

  // One clock: apply the held inputs to the reference, then sample and compare at the falling edge.
  task automatic tick();
    logic       w, f, c, popd, acc, drop;
    logic [7:0] d;
    int         lvl;
    w = wr_en; f = flush; c = clear_ovf; d = wr_data; popd = pop_pending;
    @(posedge clk);
    lvl  = exp_q.size();
    acc  = w && !f && (lvl < DEPTH || popd);
    drop = w && !f && (lvl == DEPTH) && !popd;
    if (f) begin
      exp_q.delete();
    end else begin
      if (popd && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(d);
    end
    if (drop)   exp_ovf = 1'b1;
    else if (c) exp_ovf = 1'b0;
    cycle_no++;
    @(negedge clk);
    check("level", 32'(level), 32'(exp_q.size()));
    check("empty", 32'(empty), 32'(exp_q.size() == 0));
    check("full", 32'(full), 32'(exp_q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    if (tx_strobe === 1'b1) begin
      check("strobe_single_cycle", 32'(prev_strobe), 32'd0);
      check("strobe_model_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("tx_data", 32'(tx_data), 32'(exp_q[0]));
      sent.push_back(tx_data);
      strobe_cyc.push_back(cycle_no);
    end
    pop_pending = (tx_strobe === 1'b1);
    prev_strobe = (tx_strobe === 1'b1);
    if (busy_mode == 0) begin
      if (tx_strobe === 1'b1)  busy_cnt = 10;
      else if (busy_cnt > 0)   busy_cnt--;
      tx_busy = (busy_cnt > 0);
    end
    wr_en = 1'b0; flush = 1'b0; clear_ovf = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    tick();
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (sent.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("strobe_wait_budget", 32'(sent.size() >= n), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_data"}, 32'(tx_data), 32'h00);
    check({tag, "_tx_strobe"}, 32'(tx_strobe), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ovf = 1'b0; pop_pending = 1'b0; prev_strobe = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_busy_mode(0);

    // Single byte: strobe after the second edge, level 0 -> 1 -> 0
    wr_en = 1'b1; wr_data = 8'h41;
    tick();
    check("t1_level_after_push", 32'(level), 32'd1);
    check("t1_no_strobe_yet", 32'(tx_strobe), 32'd0);
    tick();
    check("t1_strobe", 32'(tx_strobe), 32'd1);
    check("t1_tx_data", 32'(tx_data), 32'h41);
    tick();
    check("t1_strobe_dropped", 32'(tx_strobe), 32'd0);
    check("t1_level_after_pop", 32'(level), 32'd0);
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_tx_data_held", 32'(tx_data), 32'h41);
    repeat (15) tick();

    // Fill past capacity while busy, then drain through the transmitter model
    set_busy_mode(1);
    sent.delete();
    for (int i = 0; i < 16; i++) push(8'(i));
    check("t2_full", 32'(full), 32'd1);
    check("t2_level16", 32'(level), 32'd16);
    check("t2_no_ovf_yet", 32'(overflow), 32'd0);
    push(8'h10);
    check("t2_overflow", 32'(overflow), 32'd1);
    wr_en = 1'b1; wr_data = 8'h11; clear_ovf = 1'b1;
    tick();
    check("t2_set_beats_clear", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    tick();
    check("t2_ovf_cleared", 32'(overflow), 32'd0);
    set_busy_mode(0);
    wait_strobes(16, 400);
    repeat (30) tick();
    check("t2_strobe_count", 32'(sent.size()), 32'd16);
    for (int i = 0; i < 16 && i < sent.size(); i++)
      check($sformatf("t2_byte%0d", i), 32'(sent[i]), 32'(i));

    // Full queue: push in the pop cycle is accepted
    set_busy_mode(1);
    sent.delete();
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    set_busy_mode(0);
    for (int k = 0; k < 5 && !prev_strobe; k++) tick();
    check("t3_strobe_seen", 32'(prev_strobe), 32'd1);
    wr_en = 1'b1; wr_data = 8'hC3;
    tick();
    check("t3_level_stays16", 32'(level), 32'd16);
    check("t3_no_overflow", 32'(overflow), 32'd0);
    wait_strobes(17, 600);
    repeat (30) tick();
    check("t3_strobe_count", 32'(sent.size()), 32'd17);
    if (sent.size() == 17) begin
      check("t3_first", 32'(sent[0]), 32'h20);
      check("t3_last", 32'(sent[16]), 32'hC3);
    end

    // TX_BUSY stuck low: timeout path, 10-cycle strobe spacing
    set_busy_mode(2);
    sent.delete();
    strobe_cyc.delete();
    push(8'h55);
    push(8'hAA);
    wait_strobes(2, 100);
    if (sent.size() >= 2) begin
      check("t4_b0", 32'(sent[0]), 32'h55);
      check("t4_b1", 32'(sent[1]), 32'hAA);
      check("t4_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'(1 + ACKT + 1));
    end
    repeat (15) tick();

    // Flush with a simultaneous push
    set_busy_mode(1);
    sent.delete();
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    tick();
    check("t5_level0", 32'(level), 32'd0);
    check("t5_no_overflow", 32'(overflow), 32'd0);
    set_busy_mode(0);
    repeat (40) tick();
    check("t5_nothing_sent", 32'(sent.size()), 32'd0);

    // Reset in the middle of a handshake
    push(8'h77);
    push(8'h78);
    for (int k = 0; k < 5 && !prev_strobe; k++) tick();
    check("t6_strobe_seen", 32'(prev_strobe), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_values("t6_async");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_busy_mode(0);
    sent.delete();
    repeat (20) tick();
    check("t6_nothing_after_reset", 32'(sent.size()), 32'd0);

    // Random traffic against the reference
    for (int i = 0; i < 800; i++) begin
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_data   = 8'($urandom);
      clear_ovf = ($urandom_range(0, 19) == 0);
      flush     = ($urandom_range(0, 99) == 0);
      tick();
    end
    repeat (300) tick();
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
